seg_scan_capture: RTL and testbench

- Receiving end of the multiplexed 7-segment interface: samples the active-low digit select and segment lines produced by the display scanner.
- Waits for each select/segment combination to settle, then decodes the segment pattern back to a BCD nibble and stores it per digit.
- Used in on-board self-test and loopback of the stopwatch display path: the reconstructed `number` is compared against the value driven into the scanner.

---
 rtl/seg_scan_capture.sv | 179 +++++++++++++++++
 tb/tb_seg_scan_capture.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// Loopback capture of a multiplexed active-low 7-segment display: debounces select/segment
// samples, decodes them back to BCD per digit. Optional dp capture under SEG_CAPTURE_DP_EN.
module seg_scan_capture #(
   parameter int unsigned NUMBER_OF_DIGITS = 4,
   parameter int unsigned SETTLE_CYCLES    = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [3:0]                    io_sel,
   input  logic [7:0]                    io_seg,
   output logic [NUMBER_OF_DIGITS*4-1:0] number,
   output logic [NUMBER_OF_DIGITS-1:0]   digit_valid,
   output logic                          frame_done,
   output logic                          decode_err
`ifdef SEG_CAPTURE_DP_EN
   ,
   output logic [NUMBER_OF_DIGITS-1:0]   dp
`endif
);

   localparam int unsigned SAMPLE_W = 12;
   localparam int unsigned NUM_W    = NUMBER_OF_DIGITS * 4;
   localparam int unsigned CNT_W    = $clog2(SETTLE_CYCLES + 1);

   localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SETTLE_CYCLES);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_SETTLING = 2'd1;
   localparam logic [1:0] ST_COMMIT   = 2'd2;
   localparam logic [1:0] ST_HELD     = 2'd3;

   logic [SAMPLE_W-1:0]         sample_in;
   logic [SAMPLE_W-1:0]         s;
   logic [CNT_W-1:0]            cnt;
   logic [CNT_W-1:0]            cnt_n;
   logic [1:0]                  state;
   logic [1:0]                  state_n;
   logic [NUMBER_OF_DIGITS-1:0] seen;
   logic [NUMBER_OF_DIGITS-1:0] seen_n;
   logic [NUM_W-1:0]            number_n;
   logic [NUMBER_OF_DIGITS-1:0] valid_n;
   logic                        frame_n;
   logic                        err_n;
   logic [NUMBER_OF_DIGITS-1:0] dp_q;
   logic [NUMBER_OF_DIGITS-1:0] dp_n;

   logic       same;
   logic       commit;
   logic [3:0] sel_low;
   logic       sel_idle;
   logic       sel_multi;
   logic       sel_in_range;
   logic [1:0] sel_idx;
   logic       seg_ok;
   logic [3:0] seg_val;

   // Without dp capture, bit 7 is forced high so dp activity never disturbs settling.
`ifdef SEG_CAPTURE_DP_EN
   assign sample_in = {io_sel, io_seg};
   assign dp        = dp_q;
`else
   logic unused_dp;
   assign sample_in = {io_sel, 1'b1, io_seg[6:0]};
   assign unused_dp = io_seg[7] ^ (|dp_q);
`endif

   assign same   = (sample_in == s);
   assign commit = same && (state == ST_COMMIT);

   // Select classification of the settled sample
   assign sel_low      = ~s[11:8];
   assign sel_idle     = (sel_low == 4'b0000);
   assign sel_multi    = !$onehot0(sel_low);
   assign sel_in_range = (32'(sel_idx) < NUMBER_OF_DIGITS);

   always_comb begin
      sel_idx = 2'd0;
      for (int b = 0; b < 4; b++) begin
         if (sel_low[b]) sel_idx = 2'(b);
      end
   end

   // Active-high gfedcba pattern to BCD; blank maps to 0xF
   always_comb begin
      seg_ok  = 1'b1;
      seg_val = 4'h0;
      case (~s[6:0])
         7'h3F:   seg_val = 4'd0;
         7'h06:   seg_val = 4'd1;
         7'h5B:   seg_val = 4'd2;
         7'h4F:   seg_val = 4'd3;
         7'h66:   seg_val = 4'd4;
         7'h6D:   seg_val = 4'd5;
         7'h7D:   seg_val = 4'd6;
         7'h07:   seg_val = 4'd7;
         7'h7F:   seg_val = 4'd8;
         7'h6F:   seg_val = 4'd9;
         7'h00:   seg_val = 4'hF;
         default: seg_ok  = 1'b0;
      endcase
   end

   // Settle counter, state and capture next-state logic
   always_comb begin
      cnt_n    = cnt;
      state_n  = state;
      seen_n   = seen;
      number_n = number;
      valid_n  = digit_valid;
      frame_n  = 1'b0;
      err_n    = decode_err;
      dp_n     = dp_q;

      if (!same) begin
         cnt_n = '0;
      end else if (cnt != CNT_MAX) begin
         cnt_n = cnt + CNT_W'(1);
      end

      if (cnt_n == '0) begin
         state_n = ST_IDLE;
      end else if (cnt_n == CNT_COMMIT) begin
         state_n = ST_COMMIT;
      end else if (cnt_n == CNT_MAX) begin
         state_n = ST_HELD;
      end else begin
         state_n = ST_SETTLING;
      end

      if (commit) begin
         if (sel_multi) begin
            err_n = 1'b1;
         end else if (!sel_idle && sel_in_range) begin
            if (!seg_ok) begin
               err_n = 1'b1;
            end else begin
               for (int d = 0; d < NUMBER_OF_DIGITS; d++) begin
                  if (sel_idx == 2'(d)) begin
                     number_n[4*d +: 4] = seg_val;
                     valid_n[d]         = 1'b1;
                     seen_n[d]          = 1'b1;
                     dp_n[d]            = ~s[7];
                  end
               end
               if (seen_n == '1) begin
                  frame_n = 1'b1;
                  seen_n  = '0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s           <= '1;
         cnt         <= '0;
         state       <= ST_IDLE;
         seen        <= '0;
         number      <= '0;
         digit_valid <= '0;
         frame_done  <= 1'b0;
         decode_err  <= 1'b0;
         dp_q        <= '0;
      end else begin
         s           <= sample_in;
         cnt         <= cnt_n;
         state       <= state_n;
         seen        <= seen_n;
         number      <= number_n;
         digit_valid <= valid_n;
         frame_done  <= frame_n;
         decode_err  <= err_n;
         dp_q        <= dp_n;
      end
   end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scenarios plus randomized scan traffic against an
// age-based behavioural model (value first registered at edge n commits at edge n+SETTLE).
module tb_seg_scan_capture;

   localparam int unsigned ND = 4;
   localparam int unsigned SC = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [3:0]    io_sel = 4'hF;
   logic [7:0]    io_seg = 8'hFF;
   logic [15:0]   number;
   logic [3:0]    digit_valid;
   logic          frame_done;
   logic          decode_err;
`ifdef SEG_CAPTURE_DP_EN
   logic [3:0]    dp;
   logic [3:0]    m_dp;
`endif

   int checks   = 0;
   int failures = 0;
   int dut_frames = 0;

   logic [11:0] m_s;
   int          m_age;
   logic [15:0] m_num;
   logic [3:0]  m_valid;
   logic [3:0]  m_seen;
   logic        m_frame;
   logic        m_err;

   byte unsigned seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   seg_scan_capture #(.NUMBER_OF_DIGITS(ND), .SETTLE_CYCLES(SC)) dut (
      .clk         (clk),
      .rst         (rst),
      .io_sel      (io_sel),
      .io_seg      (io_seg),
      .number      (number),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .decode_err  (decode_err)
`ifdef SEG_CAPTURE_DP_EN
      ,
      .dp          (dp)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] masked(input logic [3:0] sel, input logic [7:0] seg);
`ifdef SEG_CAPTURE_DP_EN
      return {sel, seg};
`else
      return {sel, 1'b1, seg[6:0]};
`endif
   endfunction

   task automatic model_reset();
      m_s     = 12'hFFF;
      m_age   = 0;
      m_num   = '0;
      m_valid = '0;
      m_seen  = '0;
      m_frame = 1'b0;
      m_err   = 1'b0;
`ifdef SEG_CAPTURE_DP_EN
      m_dp    = '0;
`endif
   endtask

   task automatic model_commit();
      logic [3:0] low;
      logic [7:0] pat;
      int idx;
      int val;
      low = ~m_s[11:8];
      if (low == 4'b0000) return;
      if ($countones(low) > 1) begin
         m_err = 1'b1;
         return;
      end
      idx = 0;
      for (int b = 0; b < 4; b++) if (low[b]) idx = b;
      if (idx >= int'(ND)) return;
      val = -1;
      for (int d = 0; d < 10; d++) begin
         pat = seg_tab[d];
         if (pat[6:0] == m_s[6:0]) val = d;
      end
      if (m_s[6:0] == 7'h7F) val = 15;
      if (val < 0) begin
         m_err = 1'b1;
         return;
      end
      m_num[4*idx +: 4] = 4'(val);
      m_valid[idx] = 1'b1;
      m_seen[idx]  = 1'b1;
`ifdef SEG_CAPTURE_DP_EN
      m_dp[idx]    = ~m_s[7];
`endif
      if (m_seen == 4'hF) begin
         m_frame = 1'b1;
         m_seen  = '0;
      end
   endtask

   task automatic model_edge(input logic [3:0] sel, input logic [7:0] seg);
      logic [11:0] v;
      v = masked(sel, seg);
      m_frame = 1'b0;
      if (v != m_s) begin
         m_s   = v;
         m_age = 0;
      end else begin
         m_age++;
         if (m_age == int'(SC)) model_commit();
      end
   endtask

   task automatic compare_all();
      chk("number", 32'(number), 32'(m_num));
      chk("digit_valid", 32'(digit_valid), 32'(m_valid));
      chk("frame_done", 32'(frame_done), 32'(m_frame));
      chk("decode_err", 32'(decode_err), 32'(m_err));
`ifdef SEG_CAPTURE_DP_EN
      chk("dp", 32'(dp), 32'(m_dp));
`endif
      if (frame_done === 1'b1) dut_frames++;
   endtask

   task automatic step(input logic [3:0] sel, input logic [7:0] seg);
      io_sel = sel;
      io_seg = seg;
      @(posedge clk);
      model_edge(sel, seg);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_number", 32'(number), 32'h0);
      chk("rst_valid", 32'(digit_valid), 32'h0);
      chk("rst_frame", 32'(frame_done), 32'h0);
      chk("rst_err", 32'(decode_err), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int f0;
      model_reset();
      #2;
      do_reset();

      // Single digit 0 on position 0, commit latency
      for (int k = 1; k <= 6; k++) begin
         step(4'b1110, 8'hC0);
         if (k == 4) chk("t1_before_commit", 32'(digit_valid), 32'h0);
         if (k == 5) chk("t1_commit", 32'(digit_valid), 32'h1);
      end
      chk("t1_digit0", 32'(number[3:0]), 32'h0);

      // Full scan 1,2,3,4
      f0 = dut_frames;
      for (int k = 1; k <= 8; k++) step(4'b1110, 8'hF9);
      for (int k = 1; k <= 8; k++) step(4'b1101, 8'hA4);
      for (int k = 1; k <= 8; k++) step(4'b1011, 8'hB0);
      for (int k = 1; k <= 8; k++) begin
         step(4'b0111, 8'h99);
         if (k == 5) chk("t2_frame_pulse", 32'(frame_done), 32'h1);
      end
      chk("t2_number", 32'(number), 32'h4321);
      chk("t2_valid", 32'(digit_valid), 32'hF);
      chk("t2_frame_count", 32'(dut_frames - f0), 32'h1);

      // Glitch: short 2 then settled 4 on digit 1
      for (int k = 1; k <= 2; k++) step(4'b1101, 8'hA4);
      for (int k = 1; k <= 6; k++) step(4'b1101, 8'h99);
      chk("t3_number", 32'(number), 32'h4341);

      // Blank then invalid on digit 2
      for (int k = 1; k <= 8; k++) step(4'b1011, 8'hFF);
      chk("t4_blank", 32'(number[11:8]), 32'hF);
      for (int k = 1; k <= 8; k++) step(4'b1011, 8'hAA);
      chk("t4_err", 32'(decode_err), 32'h1);
      chk("t4_digit2", 32'(number[11:8]), 32'hF);

      // Multi-low select, then idle
      for (int k = 1; k <= 8; k++) step(4'b1100, 8'hC0);
      chk("t5_number", 32'(number), 32'h4F41);
      f0 = dut_frames;
      for (int k = 1; k <= 8; k++) step(4'b1111, 8'hC0);
      chk("t5_no_frame", 32'(dut_frames - f0), 32'h0);
      chk("t5_err_sticky", 32'(decode_err), 32'h1);

      // Reset mid-settle, then full settle period after release
      for (int k = 1; k <= 2; k++) step(4'b0111, 8'h92);
      #2;
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         step(4'b0111, 8'h92);
         if (k == 4) chk("t6_before_commit", 32'(digit_valid), 32'h0);
         if (k == 5) chk("t6_commit", 32'(digit_valid), 32'h8);
      end
      chk("t6_number", 32'(number), 32'h5000);

      // Randomized scan traffic
      for (int n = 0; n < 320; n++) begin
         logic [3:0] sel;
         logic [7:0] seg;
         int r;
         int hold;
         if ($urandom_range(0, 39) == 0) do_reset();
         r = int'($urandom_range(0, 9));
         if (r <= 5) begin
            sel = 4'hF;
            sel[$urandom_range(0, 3)] = 1'b0;
         end else if (r <= 7) begin
            sel = 4'hF;
         end else if (r == 8) begin
            sel = 4'hF;
            sel[0] = 1'b0;
            sel[$urandom_range(1, 3)] = 1'b0;
         end else begin
            sel = 4'($urandom());
         end
         r = int'($urandom_range(0, 9));
         if (r <= 6) seg = seg_tab[$urandom_range(0, 9)];
         else if (r == 7) seg = 8'hFF;
         else seg = 8'($urandom());
         seg[7] = 1'($urandom());
         hold = int'($urandom_range(1, 8));
         for (int k = 0; k < hold; k++) begin
            if ($urandom_range(0, 3) == 0) seg[7] = ~seg[7];
            step(sel, seg);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
